hazard_fwd_ctrl: RTL and testbench
==================================

Name: hazard_fwd_ctrl

Overview:
- Hazard and forwarding controller for the 5-stage pipelined CPU.
- Tracks destination registers of instructions in the EX, MEM and WB stages in its own shadow pipeline.
- Drives the 2-bit selects of the two EX-stage 3-input operand muxes: 00 = register-file value, 01 = EX/MEM result, 10 = MEM/WB result; 11 is never driven.
- Generates the pipeline stall for load-use hazards and for a busy multi-cycle mult/div unit.

Parameters:
- MD_CYCLES, 5, number of cycles the mult/div unit is busy after a mult/div instruction enters EX (legal range 1..15).
- CNT_W, 4, width of the mult/div busy counter; must satisfy 2^CNT_W > MD_CYCLES.

Ports:
- clk  input  1  system clock, rising edge
- reset  input  1  asynchronous, active-high reset
- id_valid  input  1  ID stage holds a real instruction (0 = bubble)
- id_rs  input  5  rs field of the ID instruction
- id_rt  input  5  rt field of the ID instruction
- id_use_rs  input  1  ID instruction reads rs
- id_use_rt  input  1  ID instruction reads rt
- id_dst  input  5  destination register of the ID instruction
- id_we  input  1  ID instruction writes the register file
- id_load  input  1  ID instruction is a load (lw)
- id_md  input  1  ID instruction is mult/multu/div/divu
- id_hilo  input  1  ID instruction reads or writes HI/LO (mfhi/mflo/mthi/mtlo)
- stall  output  1  freeze PC and IF/ID; inject a bubble into ID/EX
- fwd_a_sel  output  2  select for the EX operand-A mux
- fwd_b_sel  output  2  select for the EX operand-B mux
- md_busy  output  1  mult/div unit busy

Behaviour:
- Shadow pipeline registers, each with {valid, rs, rt, use_rs, use_rt, dst, we, load, md}: EX, MEM, WB.
- Every rising edge: WB <= MEM; MEM <= EX.
- EX <= ID fields when stall=0 and id_valid=1; otherwise EX <= bubble (valid=0, we=0, load=0, md=0).
- Reset (async, active-high): all shadow valid/we/load/md bits = 0, counter = 0, so stall=0, fwd_a_sel=00, fwd_b_sel=00, md_busy=0 immediately. Reset mid-stall or mid-mult/div aborts both instantly.
- Forwarding (combinational from shadow regs, zero latency). For operand A against EX.rs:
  - 01 if MEM.valid & MEM.we & MEM.dst!=0 & MEM.dst==EX.rs & EX.use_rs;
  - else 10 if the same condition holds on WB;
  - else 00.
  - Operand B is identical, using EX.rt/EX.use_rt.
  - MEM wins over WB when both match (youngest producer).
  - A load in MEM is never a forwarding source: a MEM match with MEM.load=1 is ignored. The load-use stall guarantees this case is unreachable for a dependent instruction.
  - Register $0 is never forwarded.
- Load-use stall: lu = EX.valid & EX.load & EX.we & EX.dst!=0 & id_valid & ((id_use_rs & id_rs==EX.dst) | (id_use_rt & id_rt==EX.dst)). Lasts exactly 1 cycle, because the load then moves to MEM and the condition clears.
- Mult/div counter:
  - Loaded with MD_CYCLES on the edge where EX.md is written with 1, i.e. an md instruction accepted from ID.
  - Otherwise decrements by 1 while nonzero; saturates at 0.
  - md_busy = (counter != 0).
- Mult/div stall: mds = id_valid & (id_md | id_hilo) & md_busy.
- stall = lu | mds. Both may be true together; stall holds until both clear.
- Back-to-back md: the second md stalls until the counter reaches 0, is accepted on the first cycle md_busy=0, and reloads the counter.
- Register-file writes occur before reads in the same cycle, so no ID-stage WB hazard exists; the block does not handle it.
- Outputs are pure functions of state and ID inputs. There is no output register stage.

Decomposition:
- Shared package (cpu_defs): FWD_RF=2'b00, FWD_EXMEM=2'b01, FWD_MEMWB=2'b10; stage-record field widths (REG_W=5).
- One natural sub-module, fwd_sel_unit: the combinational select for one operand, instantiated twice (operands A and B).

Test Plan:
- ALU chain: add $3←… then sub $4,$3,$5 back-to-back -> sub in EX gives fwd_a_sel=01 that cycle; with one nop between, fwd_a_sel=10; stall stays 0 throughout.
- Double producer: add $3 then or $3 then and $6,$3,$3 -> and in EX gives fwd_a_sel=fwd_b_sel=01 (MEM priority over WB).
- Load-use: lw $2 then add $7,$2,$1 -> stall=1 for exactly 1 cycle, EX receives a bubble, then fwd_a_sel=10 when add reaches EX.
- $0 destination: addu $0,… followed by a user of $0 -> selects stay 00, no stall.
- Mult/div, MD_CYCLES=5: mult then mflo immediately -> md_busy=1 for 5 cycles after mult enters EX; mflo stalls until md_busy falls, then is accepted.
- Reset mid-operation: assert reset during a load-use stall with the counter at 3 -> stall, md_busy and both selects go to 0 asynchronously, before the next clock edge.

Source files
------------

// File: rtl/cpu_defs.sv
// Shared definitions for the hazard/forwarding controller: mux select codes
// and the shadow-pipeline stage record.
package cpu_defs;

    localparam int unsigned REG_W = 5;
    localparam int unsigned SEL_W = 2;

    localparam logic [SEL_W-1:0] FWD_RF    = 2'b00;
    localparam logic [SEL_W-1:0] FWD_EXMEM = 2'b01;
    localparam logic [SEL_W-1:0] FWD_MEMWB = 2'b10;

    typedef struct packed {
        logic             valid;
        logic [REG_W-1:0] rs;
        logic [REG_W-1:0] rt;
        logic             use_rs;
        logic             use_rt;
        logic [REG_W-1:0] dst;
        logic             we;
        logic             load;
        logic             md;
    } stage_rec_t;

endpackage

// File: rtl/fwd_sel_unit.sv
// Operand-mux select for one EX source: youngest non-load producer wins,
// $0 is never forwarded.
module fwd_sel_unit
    import cpu_defs::*;
(
    input  logic [REG_W-1:0] i_src,
    input  logic             i_use,
    input  logic             i_mem_valid,
    input  logic             i_mem_we,
    input  logic             i_mem_load,
    input  logic [REG_W-1:0] i_mem_dst,
    input  logic             i_wb_valid,
    input  logic             i_wb_we,
    input  logic [REG_W-1:0] i_wb_dst,
    output logic [SEL_W-1:0] o_sel_c
);

    logic w_src_ok;
    logic w_mem_hit;
    logic w_wb_hit;

    assign w_src_ok  = i_use && (i_src != '0);
    assign w_mem_hit = w_src_ok && i_mem_valid && i_mem_we && !i_mem_load && (i_mem_dst == i_src);
    assign w_wb_hit  = w_src_ok && i_wb_valid && i_wb_we && (i_wb_dst == i_src);

    always_comb begin
        o_sel_c = FWD_RF;
        if (w_mem_hit) begin
            o_sel_c = FWD_EXMEM;
        end else if (w_wb_hit) begin
            o_sel_c = FWD_MEMWB;
        end
    end

endmodule

// File: rtl/hazard_fwd_ctrl.sv
// Hazard and forwarding controller: shadow EX/MEM/WB destination tracking,
// operand forwarding selects, load-use and mult/div stalls.
module hazard_fwd_ctrl
    import cpu_defs::*;
#(
    parameter int unsigned MD_CYCLES = 5,
    parameter int unsigned CNT_W     = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             id_valid,
    input  logic [REG_W-1:0] id_rs,
    input  logic [REG_W-1:0] id_rt,
    input  logic             id_use_rs,
    input  logic             id_use_rt,
    input  logic [REG_W-1:0] id_dst,
    input  logic             id_we,
    input  logic             id_load,
    input  logic             id_md,
    input  logic             id_hilo,
    output logic             stall,
    output logic [SEL_W-1:0] fwd_a_sel,
    output logic [SEL_W-1:0] fwd_b_sel,
    output logic             md_busy
);

    stage_rec_t       r_ex;
    stage_rec_t       r_mem;
    stage_rec_t       r_wb;
    logic [CNT_W-1:0] r_cnt;

    stage_rec_t w_id_rec;
    logic       w_lu;
    logic       w_mds;
    logic       w_accept;
    logic       w_unused;

    assign w_id_rec = '{valid:  1'b1,
                        rs:     id_rs,
                        rt:     id_rt,
                        use_rs: id_use_rs,
                        use_rt: id_use_rt,
                        dst:    id_dst,
                        we:     id_we,
                        load:   id_load,
                        md:     id_md};

    // Load in EX whose result the ID instruction needs: hold ID one cycle.
    assign w_lu = r_ex.valid && r_ex.load && r_ex.we && (r_ex.dst != '0) && id_valid &&
                  ((id_use_rs && (id_rs == r_ex.dst)) || (id_use_rt && (id_rt == r_ex.dst)));

    assign md_busy  = (r_cnt != '0);
    assign w_mds    = id_valid && (id_md || id_hilo) && md_busy;
    assign stall    = w_lu || w_mds;
    assign w_accept = id_valid && !stall;

    // Shadow pipeline advance and mult/div busy countdown.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_ex  <= '0;
            r_mem <= '0;
            r_wb  <= '0;
            r_cnt <= '0;
        end else begin
            r_wb  <= r_mem;
            r_mem <= r_ex;
            r_ex  <= w_accept ? w_id_rec : '0;
            if (w_accept && id_md) begin
                r_cnt <= CNT_W'(MD_CYCLES);
            end else if (r_cnt != '0) begin
                r_cnt <= r_cnt - CNT_W'(1);
            end
        end
    end

    fwd_sel_unit u_fwd_a (
        .i_src       (r_ex.rs),
        .i_use       (r_ex.use_rs),
        .i_mem_valid (r_mem.valid),
        .i_mem_we    (r_mem.we),
        .i_mem_load  (r_mem.load),
        .i_mem_dst   (r_mem.dst),
        .i_wb_valid  (r_wb.valid),
        .i_wb_we     (r_wb.we),
        .i_wb_dst    (r_wb.dst),
        .o_sel_c     (fwd_a_sel)
    );

    fwd_sel_unit u_fwd_b (
        .i_src       (r_ex.rt),
        .i_use       (r_ex.use_rt),
        .i_mem_valid (r_mem.valid),
        .i_mem_we    (r_mem.we),
        .i_mem_load  (r_mem.load),
        .i_mem_dst   (r_mem.dst),
        .i_wb_valid  (r_wb.valid),
        .i_wb_we     (r_wb.we),
        .i_wb_dst    (r_wb.dst),
        .o_sel_c     (fwd_b_sel)
    );

    // Record fields carried for pipeline fidelity but not consumed here.
    assign w_unused = ^{r_ex.md,
                        r_mem.rs, r_mem.rt, r_mem.use_rs, r_mem.use_rt, r_mem.md,
                        r_wb.rs, r_wb.rt, r_wb.use_rs, r_wb.use_rt, r_wb.load, r_wb.md};

endmodule

// File: tb/tb_hazard_fwd_ctrl.sv
// Self-checking bench for hazard_fwd_ctrl: directed test-plan sequences plus
// randomized instruction streams against an instruction-level reference model.
module tb_hazard_fwd_ctrl;

    localparam int MD_CYCLES = 5;

    typedef struct {
        logic       v;
        logic [4:0] rs;
        logic [4:0] rt;
        logic       urs;
        logic       urt;
        logic [4:0] dst;
        logic       we;
        logic       ld;
        logic       md;
        logic       hilo;
    } ins_t;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       id_valid = 1'b0;
    logic [4:0] id_rs = '0;
    logic [4:0] id_rt = '0;
    logic       id_use_rs = 1'b0;
    logic       id_use_rt = 1'b0;
    logic [4:0] id_dst = '0;
    logic       id_we = 1'b0;
    logic       id_load = 1'b0;
    logic       id_md = 1'b0;
    logic       id_hilo = 1'b0;
    logic       stall;
    logic [1:0] fwd_a_sel;
    logic [1:0] fwd_b_sel;
    logic       md_busy;

    int n_checks = 0;
    int n_fail = 0;

    // Model: instructions resident in EX, MEM, WB and the edge of last md issue.
    ins_t m_stage[3];
    int   m_cyc;
    int   m_md_edge;

    always #5 clk = ~clk;

    hazard_fwd_ctrl #(.MD_CYCLES(MD_CYCLES), .CNT_W(4)) dut (
        .clk       (clk),
        .reset     (reset),
        .id_valid  (id_valid),
        .id_rs     (id_rs),
        .id_rt     (id_rt),
        .id_use_rs (id_use_rs),
        .id_use_rt (id_use_rt),
        .id_dst    (id_dst),
        .id_we     (id_we),
        .id_load   (id_load),
        .id_md     (id_md),
        .id_hilo   (id_hilo),
        .stall     (stall),
        .fwd_a_sel (fwd_a_sel),
        .fwd_b_sel (fwd_b_sel),
        .md_busy   (md_busy)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic ins_t nop();
        ins_t r;
        r = '{v: 1'b0, rs: 5'd0, rt: 5'd0, urs: 1'b0, urt: 1'b0, dst: 5'd0,
              we: 1'b0, ld: 1'b0, md: 1'b0, hilo: 1'b0};
        return r;
    endfunction

    function automatic ins_t mk(input logic [4:0] rs, input logic urs, input logic [4:0] rt,
                                input logic urt, input logic [4:0] dst, input logic we,
                                input logic ld, input logic md, input logic hilo);
        ins_t r;
        r = '{v: 1'b1, rs: rs, rt: rt, urs: urs, urt: urt, dst: dst,
              we: we, ld: ld, md: md, hilo: hilo};
        return r;
    endfunction

    function automatic ins_t rand_ins();
        ins_t r;
        r.v    = ($urandom % 8) != 0;
        r.rs   = 5'($urandom % 4);
        r.rt   = 5'($urandom % 4);
        r.urs  = 1'($urandom % 2);
        r.urt  = 1'($urandom % 2);
        r.dst  = 5'($urandom % 4);
        r.we   = ($urandom % 4) != 0;
        r.ld   = ($urandom % 4) == 0;
        r.md   = ($urandom % 10) == 0;
        r.hilo = ($urandom % 10) == 0;
        return r;
    endfunction

    function automatic logic m_busy();
        return (m_cyc - m_md_edge) < MD_CYCLES;
    endfunction

    function automatic logic [1:0] m_fwd(input logic [4:0] src, input logic use_src);
        if (!m_stage[0].v || !use_src || src == 5'd0) return 2'b00;
        if (m_stage[1].v && m_stage[1].we && !m_stage[1].ld && m_stage[1].dst == src) return 2'b01;
        if (m_stage[2].v && m_stage[2].we && m_stage[2].dst == src) return 2'b10;
        return 2'b00;
    endfunction

    function automatic logic m_stall(input ins_t id);
        logic lu;
        logic mds;
        lu  = m_stage[0].v && m_stage[0].ld && m_stage[0].we && m_stage[0].dst != 5'd0 && id.v &&
              ((id.urs && id.rs == m_stage[0].dst) || (id.urt && id.rt == m_stage[0].dst));
        mds = id.v && (id.md || id.hilo) && m_busy();
        return lu || mds;
    endfunction

    function automatic void m_reset();
        for (int i = 0; i < 3; i++) m_stage[i] = nop();
        m_cyc     = 0;
        m_md_edge = -1000;
    endfunction

    task automatic drive(input ins_t in);
        id_valid  = in.v;
        id_rs     = in.rs;
        id_rt     = in.rt;
        id_use_rs = in.urs;
        id_use_rt = in.urt;
        id_dst    = in.dst;
        id_we     = in.we;
        id_load   = in.ld;
        id_md     = in.md;
        id_hilo   = in.hilo;
    endtask

    // Present one ID instruction for one cycle, compare, then advance the model.
    task automatic step(input ins_t in);
        logic st;
        drive(in);
        #1;
        st = m_stall(in);
        chk("stall", 32'(stall), 32'(st));
        chk("fwd_a", 32'(fwd_a_sel), 32'(m_fwd(m_stage[0].rs, m_stage[0].urs)));
        chk("fwd_b", 32'(fwd_b_sel), 32'(m_fwd(m_stage[0].rt, m_stage[0].urt)));
        chk("md_busy", 32'(md_busy), 32'(m_busy()));
        @(posedge clk);
        m_cyc++;
        m_stage[2] = m_stage[1];
        m_stage[1] = m_stage[0];
        if (!st && in.v) begin
            m_stage[0] = in;
            if (in.md) m_md_edge = m_cyc;
        end else begin
            m_stage[0] = nop();
        end
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        m_reset();
        @(posedge clk);
        #2;
        reset = 1'b0;
    endtask

    initial begin
        ins_t mult_i;
        ins_t lw2;
        ins_t add_dep;
        m_reset();
        drive(nop());
        #2;
        chk("rst_stall", 32'(stall), 32'd0);
        chk("rst_fwd_a", 32'(fwd_a_sel), 32'd0);
        chk("rst_fwd_b", 32'(fwd_b_sel), 32'd0);
        chk("rst_busy", 32'(md_busy), 32'd0);
        do_reset();

        // ALU chain back-to-back, then with one nop between.
        step(mk(5'd1, 1, 5'd2, 1, 5'd3, 1, 0, 0, 0));
        step(mk(5'd3, 1, 5'd5, 1, 5'd4, 1, 0, 0, 0));
        drive(nop()); #1;
        chk("alu_chain_mem", 32'(fwd_a_sel), 32'd1);
        step(nop());
        step(mk(5'd1, 1, 5'd2, 1, 5'd3, 1, 0, 0, 0));
        step(nop());
        step(mk(5'd3, 1, 5'd5, 1, 5'd4, 1, 0, 0, 0));
        drive(nop()); #1;
        chk("alu_chain_wb", 32'(fwd_a_sel), 32'd2);
        step(nop());

        // Double producer: MEM has priority over WB.
        step(mk(5'd1, 1, 5'd2, 1, 5'd3, 1, 0, 0, 0));
        step(mk(5'd1, 1, 5'd2, 1, 5'd3, 1, 0, 0, 0));
        step(mk(5'd3, 1, 5'd3, 1, 5'd6, 1, 0, 0, 0));
        drive(nop()); #1;
        chk("dbl_a", 32'(fwd_a_sel), 32'd1);
        chk("dbl_b", 32'(fwd_b_sel), 32'd1);
        step(nop());

        // Load-use: one stall cycle, then WB forward.
        step(mk(5'd1, 1, 5'd0, 0, 5'd2, 1, 1, 0, 0));
        add_dep = mk(5'd2, 1, 5'd1, 1, 5'd7, 1, 0, 0, 0);
        drive(add_dep); #1;
        chk("lu_stall", 32'(stall), 32'd1);
        step(add_dep);
        step(add_dep);
        drive(nop()); #1;
        chk("lu_fwd_wb", 32'(fwd_a_sel), 32'd2);
        step(nop());

        // $0 destination is never a source.
        step(mk(5'd1, 1, 5'd2, 1, 5'd0, 1, 0, 0, 0));
        step(mk(5'd0, 1, 5'd0, 1, 5'd8, 1, 0, 0, 0));
        step(nop());

        // mult then mflo: mflo waits for busy to drop.
        step(mk(5'd1, 1, 5'd2, 1, 5'd0, 0, 0, 1, 0));
        for (int i = 0; i < MD_CYCLES + 2; i++) step(mk(5'd0, 0, 5'd0, 0, 5'd9, 1, 0, 0, 1));
        step(nop());

        // Reset during a load-use stall with counter at 3.
        do_reset();
        mult_i = mk(5'd1, 1, 5'd2, 1, 5'd0, 0, 0, 1, 0);
        lw2    = mk(5'd1, 1, 5'd0, 0, 5'd2, 1, 1, 0, 0);
        step(mult_i);
        step(nop());
        step(lw2);
        drive(add_dep); #1;
        chk("pre_rst_stall", 32'(stall), 32'd1);
        chk("pre_rst_busy", 32'(md_busy), 32'd1);
        reset = 1'b1;
        #1;
        chk("async_rst_stall", 32'(stall), 32'd0);
        chk("async_rst_busy", 32'(md_busy), 32'd0);
        chk("async_rst_fwd_a", 32'(fwd_a_sel), 32'd0);
        chk("async_rst_fwd_b", 32'(fwd_b_sel), 32'd0);
        do_reset();

        // Randomized instruction stream.
        for (int i = 0; i < 800; i++) step(rand_ins());

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
